axi_rd_arbiter: RTL and testbench

Two-master AXI read-channel arbiter that sits directly downstream of the instruction cache's AXI read port (`i_*`) and the data cache's read port (`d_*`). It merges them onto a single AXI read master toward the memory interconnect. Exactly one burst is outstanding at a time. The address channel is registered at grant. The read-data channel is forwarded combinationally so that uncached instruction fetches see `rdata` in the same cycle it arrives.

---
 rtl/axi_rd_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//
// Merges the instruction-cache (i_*) and data-cache (d_*) AXI read ports onto
// a single AXI read master. Only one burst is in flight at a time. The AR
// channel is registered at grant. The R channel is forwarded combinationally
// to the owning side, so read data reaches the requester in the cycle it
// arrives.
//
// Configuration macro:
//   AXI_RD_RR_EN - when defined, two simultaneous requests are arbitrated
//                  round-robin using a 1-bit last_owner register. When
//                  undefined, D always wins over I.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   i_ar*/i_arvalid, i_arready   - I-side read address channel
//   i_rdata/i_rlast/i_rvalid,
//   i_rready                     - I-side read data channel
//   d_ar*/d_arvalid, d_arready   - D-side read address channel
//   d_rdata/d_rlast/d_rvalid,
//   d_rready                     - D-side read data channel
//   araddr/arlen/arsize/arid/
//   arburst/arvalid, arready     - master read address channel
//   rdata/rresp/rlast/rvalid,
//   rready                       - master read data channel (rresp ignored)

module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int I_ID   = 0,
  parameter int D_ID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rvalid,
  input  logic              d_rready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [ID_W-1:0]   arid,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;
  logic   owner;      // 0 = I side, 1 = D side
  logic   grant_d;
  logic   req_any;

  // Response status is not propagated to either cache.
  logic unused_rresp;
  assign unused_rresp = ^rresp;

  assign req_any = i_arvalid | d_arvalid;

`ifdef AXI_RD_RR_EN
  logic last_owner;

  // Round-robin: on a tie the side that did not win last time is granted;
  // a lone requester always wins.
  always_comb begin
    grant_d = d_arvalid & (~i_arvalid | ~last_owner);
  end

  // last_owner follows every grant so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && req_any) begin
      last_owner <= grant_d;
    end
  end
`else
  // Fixed priority: the data side wins whenever it is requesting.
  always_comb begin
    grant_d = d_arvalid;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Burst end comes only from rlast; no beat counting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ADDR;
      ADDR:    if (arvalid && arready) state_nxt = DATA;
      DATA:    if (rvalid && rready && rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // AR registers are loaded from the winner at grant and arvalid is held
  // until the interconnect accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= 1'b0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      arid    <= '0;
      arburst <= 2'b01;
    end else if (state == IDLE && req_any) begin
      owner   <= grant_d;
      arvalid <= 1'b1;
      araddr  <= grant_d ? d_araddr : i_araddr;
      arlen   <= grant_d ? d_arlen  : i_arlen;
      arsize  <= grant_d ? d_arsize : i_arsize;
      arid    <= grant_d ? ID_W'(D_ID) : ID_W'(I_ID);
      arburst <= 2'b01;
    end else if (state == ADDR && arready) begin
      arvalid <= 1'b0;
    end
  end

  // Requester-facing outputs. Read data fans out to both sides; only the
  // owner sees valid/last, and only the owner's rready reaches the master.
  always_comb begin
    i_rdata   = rdata;
    d_rdata   = rdata;
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    rready    = 1'b0;
    case (state)
      ADDR: begin
        i_arready = ~owner & arready;
        d_arready = owner & arready;
      end
      DATA: begin
        if (owner) begin
          d_rvalid = rvalid;
          d_rlast  = rlast;
          rready   = d_rready;
        end else begin
          i_rvalid = rvalid;
          i_rlast  = rlast;
          rready   = i_rready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
//
// Scoreboard bench for axi_rd_arbiter. Scenario code pushes the expected AR
// transfers and R beats (hand-computed addresses and data) into queues.
// Requester and memory-slave processes drive the DUT, and a monitor pops and
// compares every time the DUT presents an AR handshake or a forwarded beat.

module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, araddr;
  logic [7:0]  i_arlen, d_arlen, arlen;
  logic [2:0]  i_arsize, d_arsize, arsize;
  logic        i_arvalid, i_arready, d_arvalid, d_arready;
  logic [31:0] i_rdata, d_rdata, rdata;
  logic        i_rlast, i_rvalid, i_rready;
  logic        d_rlast, d_rvalid, d_rready;
  logic [3:0]  arid;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
  } ar_t;

  typedef struct packed {
    logic        side;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } req_t;

  ar_t         ar_q[$];
  beat_t       beat_q[$];
  logic [31:0] base_q[$];
  req_t        iq[$];
  req_t        dq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rlast_cyc = 0;
  int   last_gap = 0;
  logic prev_arvalid = 1'b0;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arid(arid),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Queue a request for one cache side; call at a negedge.
  task automatic applyStimulus(input logic side, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size);
    req_t r;
    r.addr = addr;
    r.len  = len;
    r.size = size;
    if (side) dq.push_back(r);
    else      iq.push_back(r);
  endtask

  // Record the expected grant and the first nbeats beats, in grant order.
  task automatic expectBurst(input logic side, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [31:0] base, input int nbeats);
    ar_t a;
    a.addr = addr;
    a.len  = len;
    a.size = size;
    a.id   = side ? 4'd1 : 4'd0;
    ar_q.push_back(a);
    base_q.push_back(base);
    for (int k = 0; k < nbeats; k++) begin
      beat_t b;
      b.side = side;
      b.data = base + 32'(k);
      b.last = (k == int'(len));
      beat_q.push_back(b);
    end
  endtask

  task automatic checkBeat(input logic side, input logic [31:0] data, input logic last);
    beat_t b;
    if (beat_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_beat actual=side%0d data 0x%08h required=no beat", side, data);
    end else begin
      b = beat_q.pop_front();
      checkOutput("beat_side", 32'(side), 32'(b.side));
      checkOutput("beat_data", data, b.data);
      checkOutput("beat_last", 32'(last), 32'(b.last));
      checkOutput("rdata_fanout", side ? i_rdata : d_rdata, b.data);
    end
  endtask

  // Wait (bounded) until every expected transfer has been seen and the bus is quiet.
  task automatic drain(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ar_q.size() != 0 || beat_q.size() != 0 || rvalid || arvalid) && n < limit);
    checkOutput(name, 32'(ar_q.size() + beat_q.size()), 32'd0);
  endtask

  // I-side requester: presents queued requests and holds them until accepted.
  logic i_hs;
  initial begin
    i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_arsize = '0;
    forever begin
      req_t r;
      @(negedge clk);
      i_hs = i_arvalid && i_arready;
      @(posedge clk);
      #1;
      if (i_hs) i_arvalid = 1'b0;
      if (!i_arvalid && iq.size() > 0) begin
        r = iq.pop_front();
        i_araddr = r.addr; i_arlen = r.len; i_arsize = r.size; i_arvalid = 1'b1;
      end
    end
  end

  // D-side requester, same behaviour.
  logic d_hs;
  initial begin
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_arsize = '0;
    forever begin
      req_t r;
      @(negedge clk);
      d_hs = d_arvalid && d_arready;
      @(posedge clk);
      #1;
      if (d_hs) d_arvalid = 1'b0;
      if (!d_arvalid && dq.size() > 0) begin
        r = dq.pop_front();
        d_araddr = r.addr; d_arlen = r.len; d_arsize = r.size; d_arvalid = 1'b1;
      end
    end
  end

  // Memory slave: always ready on AR, then returns arlen+1 beats of base+k,
  // holding each beat until rready. A reset aborts the burst.
  logic        s_rst, s_ar, s_r, sl_busy;
  logic [7:0]  s_len;
  logic [31:0] sl_base;
  int          sl_n, sl_k;
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
    sl_busy = 1'b0; sl_n = 0; sl_k = 0; sl_base = '0;
    @(posedge clk);
    #1 arready = 1'b1;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_ar  = (arvalid === 1'b1) && arready;
      s_r   = rvalid && (rready === 1'b1);
      s_len = arlen;
      @(posedge clk);
      #1;
      if (s_rst) begin
        rvalid = 1'b0; rlast = 1'b0; sl_busy = 1'b0;
      end else if (!sl_busy) begin
        if (s_ar) begin
          sl_n    = int'(s_len) + 1;
          sl_k    = 0;
          sl_base = (base_q.size() > 0) ? base_q.pop_front() : 32'h0;
          sl_busy = 1'b1;
          rvalid  = 1'b1;
          rdata   = sl_base;
          rlast   = (sl_n == 1);
        end
      end else if (s_r) begin
        sl_k++;
        if (sl_k == sl_n) begin
          rvalid = 1'b0; rlast = 1'b0; sl_busy = 1'b0;
        end else begin
          rdata = sl_base + 32'(sl_k);
          rlast = (sl_k == sl_n - 1);
        end
      end
    end
  end

  // Monitor: compares every AR handshake and every forwarded beat against
  // the scoreboard, and tracks the gap between rlast and the next arvalid.
  initial begin
    forever begin
      ar_t e;
      @(negedge clk);
      cyc++;
      if (arvalid === 1'b1 && prev_arvalid !== 1'b1) last_gap = cyc - last_rlast_cyc;
      prev_arvalid = arvalid;
      if (arvalid === 1'b1 && arready === 1'b1) begin
        if (ar_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ar actual=araddr 0x%08h required=no grant", araddr);
        end else begin
          e = ar_q.pop_front();
          checkOutput("ar_addr", araddr, e.addr);
          checkOutput("ar_len", 32'(arlen), 32'(e.len));
          checkOutput("ar_size", 32'(arsize), 32'(e.size));
          checkOutput("ar_id", 32'(arid), 32'(e.id));
          checkOutput("ar_burst", 32'(arburst), 32'd1);
          checkOutput("i_arready_grant", 32'(i_arready), 32'(e.id == 4'd0));
          checkOutput("d_arready_grant", 32'(d_arready), 32'(e.id == 4'd1));
        end
      end
      if (i_rvalid === 1'b1 && i_rready) checkBeat(1'b0, i_rdata, i_rlast);
      if (d_rvalid === 1'b1 && d_rready) checkBeat(1'b1, d_rdata, d_rlast);
      if (rvalid) checkOutput("r_isolation", 32'(i_rvalid & d_rvalid), 32'd0);
      if (rvalid && rready === 1'b1 && rlast) last_rlast_cyc = cyc;
    end
  end

  // Directed scenarios.
  initial begin
    int n;
    rst = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    @(negedge clk);
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    checkOutput("rst_arlen", 32'(arlen), 32'd0);
    checkOutput("rst_arsize", 32'(arsize), 32'd0);
    checkOutput("rst_arid", 32'(arid), 32'd0);
    checkOutput("rst_arburst", 32'(arburst), 32'd1);
    checkOutput("rst_rready", 32'(rready), 32'd0);
    checkOutput("rst_arready", 32'({i_arready, d_arready}), 32'd0);
    checkOutput("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    checkOutput("rst_rlast", 32'({i_rlast, d_rlast}), 32'd0);

    // I line refill: 16 beats, grant one cycle after the request.
    $display("[TB] I line refill");
    expectBurst(1'b0, 32'h1FC0_0040, 8'd15, 3'd2, 32'h1000_0000, 16);
    applyStimulus(1'b0, 32'h1FC0_0040, 8'd15, 3'd2);
    @(negedge clk);
    checkOutput("t1_arvalid_n", 32'(arvalid), 32'd0);
    checkOutput("t1_i_arvalid_n", 32'(i_arvalid), 32'd1);
    @(negedge clk);
    checkOutput("t1_arvalid_n1", 32'(arvalid), 32'd1);
    checkOutput("t1_i_arready_n1", 32'(i_arready), 32'd1);
    @(negedge clk);
    checkOutput("t1_rready_data", 32'(rready), 32'd1);
    drain("t1_drain", 100);
    checkOutput("t1_idle_rready", 32'(rready), 32'd0);
    checkOutput("t1_idle_arvalid", 32'(arvalid), 32'd0);

    // Uncached single beat: data visible in the beat cycle, D side quiet.
    $display("[TB] uncached single beat");
    expectBurst(1'b0, 32'h0000_1000, 8'd0, 3'd2, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b0, 32'h0000_1000, 8'd0, 3'd2);
    drain("t4_drain", 40);

    // Simultaneous requests: D first, I held, then I after one dead cycle.
    $display("[TB] simultaneous requests");
    expectBurst(1'b1, 32'h8000_0100, 8'd0, 3'd2, 32'h2000_0000, 1);
    expectBurst(1'b0, 32'h1FC0_0100, 8'd3, 3'd2, 32'h3000_0000, 4);
    applyStimulus(1'b1, 32'h8000_0100, 8'd0, 3'd2);
    applyStimulus(1'b0, 32'h1FC0_0100, 8'd3, 3'd2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_arid_first", 32'(arid), 32'd1);
    checkOutput("t2_i_arready_held", 32'(i_arready), 32'd0);
    drain("t2_drain", 60);
    checkOutput("t2_gap", 32'(last_gap), 32'd2);

    // Back-pressure on D: rready follows d_rready, beat held until accepted.
    $display("[TB] back-pressure");
    @(posedge clk);
    #1 d_rready = 1'b0;
    @(negedge clk);
    expectBurst(1'b1, 32'h8000_0300, 8'd3, 3'd2, 32'h5000_0000, 4);
    applyStimulus(1'b1, 32'h8000_0300, 8'd3, 3'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_rvalid !== 1'b1 && n < 20);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_rready", 32'(rready), 32'd0);
      checkOutput("bp_d_rvalid", 32'(d_rvalid), 32'd1);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 d_rready = 1'b1;
    drain("t5_drain", 40);

    // Reset during beat 5 of an I refill, then a normal D grant.
    $display("[TB] reset mid-burst");
    @(negedge clk);
    expectBurst(1'b0, 32'h1FC0_0080, 8'd15, 3'd2, 32'h6000_0000, 5);
    applyStimulus(1'b0, 32'h1FC0_0080, 8'd15, 3'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_rvalid === 1'b1 && i_rdata == 32'h6000_0003) && n < 40);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_arvalid", 32'(arvalid), 32'd0);
    checkOutput("t6_rready", 32'(rready), 32'd0);
    checkOutput("t6_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("t6_beats_seen", 32'(beat_q.size()), 32'd0);
    expectBurst(1'b1, 32'h8000_0200, 8'd1, 3'd2, 32'h7000_0000, 2);
    applyStimulus(1'b1, 32'h8000_0200, 8'd1, 3'd2);
    drain("t6_drain", 40);

    // Clean reset, then continuous requests from both sides for 4 bursts.
    $display("[TB] continuous requests");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`ifdef AXI_RD_RR_EN
    expectBurst(1'b1, 32'h8000_1000, 8'd1, 3'd2, 32'hA000_0000, 2);
    expectBurst(1'b0, 32'h1FC0_1000, 8'd1, 3'd2, 32'hB000_0000, 2);
    expectBurst(1'b1, 32'h8000_2000, 8'd1, 3'd2, 32'hA100_0000, 2);
    expectBurst(1'b0, 32'h1FC0_2000, 8'd1, 3'd2, 32'hB100_0000, 2);
`else
    expectBurst(1'b1, 32'h8000_1000, 8'd1, 3'd2, 32'hA000_0000, 2);
    expectBurst(1'b1, 32'h8000_2000, 8'd1, 3'd2, 32'hA100_0000, 2);
    expectBurst(1'b0, 32'h1FC0_1000, 8'd1, 3'd2, 32'hB000_0000, 2);
    expectBurst(1'b0, 32'h1FC0_2000, 8'd1, 3'd2, 32'hB100_0000, 2);
`endif
    applyStimulus(1'b0, 32'h1FC0_1000, 8'd1, 3'd2);
    applyStimulus(1'b0, 32'h1FC0_2000, 8'd1, 3'd2);
    applyStimulus(1'b1, 32'h8000_1000, 8'd1, 3'd2);
    applyStimulus(1'b1, 32'h8000_2000, 8'd1, 3'd2);
    drain("t3_drain", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
